// File: rtl/cdb_arbiter_if.sv
// Result-bus bundle between the functional units and the CDB arbiter.
// master = FU side, slave = arbiter side.
`ifndef XLEN
`define XLEN 32
`endif

interface cdb_arbiter_if #(
  parameter int NUM_FU = 4,
  parameter int CDB_W  = 2,
  parameter int TAG_W  = 5
);
  logic [NUM_FU-1:0]         fu_result_valid;
  logic [NUM_FU*TAG_W-1:0]   fu_tag;
  logic [NUM_FU*`XLEN-1:0]   fu_value;
  logic [NUM_FU-1:0]         fu_take_branch;
  logic [NUM_FU-1:0]         fu_selected;
  logic [CDB_W-1:0]          cdb_valid;
  logic [CDB_W*TAG_W-1:0]    cdb_tag;
  logic [CDB_W*`XLEN-1:0]    cdb_value;
  logic [CDB_W-1:0]          cdb_take_branch;

  modport master (
    output fu_result_valid, fu_tag, fu_value, fu_take_branch,
    input  fu_selected, cdb_valid, cdb_tag, cdb_value,
    input  cdb_take_branch
  );

  modport slave (
    input  fu_result_valid, fu_tag, fu_value, fu_take_branch,
    output fu_selected, cdb_valid, cdb_tag, cdb_value,
    output cdb_take_branch
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: grants up to CDB_W FU results per cycle.
// Define CDB_ROUND_ROBIN_EN for a rotating priority pointer.
`ifndef XLEN
`define XLEN 32
`endif

module cdb_arbiter #(
  parameter int NUM_FU = 4,
  parameter int CDB_W  = 2,
  parameter int TAG_W  = 5
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         squash,
  cdb_arbiter_if.slave bus
);
  localparam int XW    = `XLEN;
  localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [CDB_W-1:0]       valid_q, valid_d;
  logic [CDB_W*TAG_W-1:0] tag_q, tag_d;
  logic [CDB_W*XW-1:0]    val_q, val_d;
  logic [CDB_W-1:0]       tb_q, tb_d;
  logic [NUM_FU-1:0]      sel_d;

  // Pass 0 scans ptr..NUM_FU-1, pass 1 wraps over 0..ptr-1.
  always_comb begin
    int cnt;
    cnt     = 0;
    sel_d   = '0;
    valid_d = '0;
    tag_d   = '0;
    val_d   = '0;
    tb_d    = '0;
    ptr_d   = ptr_q;
    if (!reset && !squash) begin
      for (int p = 0; p < 2; p++) begin
        for (int i = 0; i < NUM_FU; i++) begin
          if (((p == 0) == (i >= int'(ptr_q))) &&
              bus.fu_result_valid[i] && (cnt < CDB_W)) begin
            sel_d[i] = 1'b1;
            for (int k = 0; k < CDB_W; k++) begin
              if (k == cnt) begin
                valid_d[k]              = 1'b1;
                tag_d[k*TAG_W +: TAG_W] = bus.fu_tag[i*TAG_W +: TAG_W];
                val_d[k*XW +: XW]       = bus.fu_value[i*XW +: XW];
                tb_d[k]                 = bus.fu_take_branch[i];
              end
            end
            cnt = cnt + 1;
`ifdef CDB_ROUND_ROBIN_EN
            ptr_d = (i == NUM_FU - 1) ? '0 : PTR_W'(i + 1);
`endif
          end
        end
      end
    end
`ifndef CDB_ROUND_ROBIN_EN
    ptr_d = '0;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q   <= '0;
      valid_q <= '0;
      tag_q   <= '0;
      val_q   <= '0;
      tb_q    <= '0;
    end else if (squash) begin
      valid_q <= '0;
      tag_q   <= '0;
      val_q   <= '0;
      tb_q    <= '0;
    end else begin
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      tag_q   <= tag_d;
      val_q   <= val_d;
      tb_q    <= tb_d;
    end
  end

  assign bus.fu_selected     = sel_d;
  assign bus.cdb_valid       = valid_q;
  assign bus.cdb_tag         = tag_q;
  assign bus.cdb_value       = val_q;
  assign bus.cdb_take_branch = tb_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: vector table plus scoreboard of CDB output.
// Expectations follow CDB_ROUND_ROBIN_EN when it is defined.
`ifndef XLEN
`define XLEN 32
`endif

module tb_cdb_arbiter;
  localparam int NF = 4;
  localparam int CW = 2;
  localparam int TW = 5;
  localparam int XW = `XLEN;

  typedef struct packed {
    logic [CW-1:0]    v;
    logic [CW*TW-1:0] tag;
    logic [CW*XW-1:0] val;
    logic [CW-1:0]    tb;
  } exp_t;

  typedef struct {
    logic          rst;
    logic          sq;
    logic [NF-1:0] vld;
    logic [NF-1:0] sel;
    logic [CW-1:0] cv;
    int            l0;
    int            l1;
  } vec_t;

  logic clock = 1'b0;
  logic reset;
  logic squash;

  cdb_arbiter_if #(.NUM_FU(NF), .CDB_W(CW), .TAG_W(TW)) bus ();

  cdb_arbiter #(.NUM_FU(NF), .CDB_W(CW), .TAG_W(TW)) dut (
    .clock  (clock),
    .reset  (reset),
    .squash (squash),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  exp_t sb[$];
  vec_t tbl[$];
  int   n_run  = 0;
  int   n_fail = 0;

  function automatic logic [XW-1:0] val_of(int i);
    return XW'(32'hC0DE_0000 + i);
  endfunction

  function automatic logic tb_of(int i);
    return (i % 2) == 0;
  endfunction

  function automatic exp_t mk(logic [CW-1:0] cv, int l0, int l1);
    exp_t e;
    int   fu[CW];
    e     = '0;
    fu[0] = l0;
    fu[1] = l1;
    for (int k = 0; k < CW; k++) begin
      if (cv[k]) begin
        e.v[k]            = 1'b1;
        e.tag[k*TW +: TW] = TW'(fu[k] + 1);
        e.val[k*XW +: XW] = val_of(fu[k]);
        e.tb[k]           = tb_of(fu[k]);
      end
    end
    return e;
  endfunction

  task automatic cyc(input logic r, input logic s,
                     input logic [NF-1:0] v,
                     input logic [NF-1:0] sel,
                     input exp_t e, input string nm);
    exp_t got;
    exp_t want;
    reset  = r;
    squash = s;
    bus.fu_result_valid = v;
    #1;
    n_run++;
    if (bus.fu_selected !== sel) begin
      n_fail++;
      $display("FAIL %s sel: got %b want %b",
               nm, bus.fu_selected, sel);
    end
    sb.push_back(e);
    @(posedge clock);
    #1;
    got.v   = bus.cdb_valid;
    got.tag = bus.cdb_tag;
    got.val = bus.cdb_value;
    got.tb  = bus.cdb_take_branch;
    want    = sb.pop_front();
    n_run++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s cdb: got %h want %h", nm, got, want);
    end
    @(negedge clock);
  endtask

  initial begin
    reset  = 1'b1;
    squash = 1'b0;
    bus.fu_result_valid = '0;
    for (int i = 0; i < NF; i++) begin
      bus.fu_tag[i*TW +: TW]   = TW'(i + 1);
      bus.fu_value[i*XW +: XW] = val_of(i);
      bus.fu_take_branch[i]    = tb_of(i);
    end

    tbl.push_back('{1'b1, 1'b0, 4'b1111, 4'b0000, 2'b00, 0, 0});
    tbl.push_back('{1'b1, 1'b0, 4'b0000, 4'b0000, 2'b00, 0, 0});
    tbl.push_back('{1'b0, 1'b0, 4'b0000, 4'b0000, 2'b00, 0, 0});
    tbl.push_back('{1'b0, 1'b0, 4'b0000, 4'b0000, 2'b00, 0, 0});
`ifdef CDB_ROUND_ROBIN_EN
    tbl.push_back('{1'b0, 1'b0, 4'b1111, 4'b0011, 2'b11, 0, 1});
    tbl.push_back('{1'b0, 1'b0, 4'b1111, 4'b1100, 2'b11, 2, 3});
    tbl.push_back('{1'b0, 1'b0, 4'b0100, 4'b0100, 2'b01, 2, 0});
    tbl.push_back('{1'b0, 1'b0, 4'b1001, 4'b1001, 2'b11, 3, 0});
    tbl.push_back('{1'b0, 1'b1, 4'b1111, 4'b0000, 2'b00, 0, 0});
    tbl.push_back('{1'b0, 1'b0, 4'b1111, 4'b0110, 2'b11, 1, 2});
    tbl.push_back('{1'b0, 1'b0, 4'b1111, 4'b1001, 2'b11, 3, 0});
    tbl.push_back('{1'b0, 1'b0, 4'b0000, 4'b0000, 2'b00, 0, 0});
    tbl.push_back('{1'b0, 1'b0, 4'b0001, 4'b0001, 2'b01, 0, 0});
    tbl.push_back('{1'b0, 1'b0, 4'b1110, 4'b0110, 2'b11, 1, 2});
    tbl.push_back('{1'b1, 1'b1, 4'b1111, 4'b0000, 2'b00, 0, 0});
    tbl.push_back('{1'b0, 1'b0, 4'b1111, 4'b0011, 2'b11, 0, 1});
`else
    tbl.push_back('{1'b0, 1'b0, 4'b1111, 4'b0011, 2'b11, 0, 1});
    tbl.push_back('{1'b0, 1'b0, 4'b1111, 4'b0011, 2'b11, 0, 1});
    tbl.push_back('{1'b0, 1'b0, 4'b1111, 4'b0011, 2'b11, 0, 1});
    tbl.push_back('{1'b0, 1'b0, 4'b1001, 4'b1001, 2'b11, 0, 3});
    tbl.push_back('{1'b0, 1'b0, 4'b0100, 4'b0100, 2'b01, 2, 0});
    tbl.push_back('{1'b0, 1'b1, 4'b1111, 4'b0000, 2'b00, 0, 0});
    tbl.push_back('{1'b0, 1'b0, 4'b1010, 4'b1010, 2'b11, 1, 3});
    tbl.push_back('{1'b0, 1'b0, 4'b1000, 4'b1000, 2'b01, 3, 0});
    tbl.push_back('{1'b0, 1'b0, 4'b0110, 4'b0110, 2'b11, 1, 2});
    tbl.push_back('{1'b0, 1'b0, 4'b1110, 4'b0110, 2'b11, 1, 2});
    tbl.push_back('{1'b1, 1'b1, 4'b1111, 4'b0000, 2'b00, 0, 0});
    tbl.push_back('{1'b0, 1'b0, 4'b1111, 4'b0011, 2'b11, 0, 1});
`endif

    @(negedge clock);
    foreach (tbl[n]) begin
      cyc(tbl[n].rst, tbl[n].sq, tbl[n].vld, tbl[n].sel,
          mk(tbl[n].cv, tbl[n].l0, tbl[n].l1),
          $sformatf("vec%0d", n));
    end

    // Mid-stream reset: drop the broadcast and restart the pointer.
    cyc(1'b1, 1'b0, 4'b0000, 4'b0000, mk(2'b00, 0, 0), "rst_mid");
    begin
      exp_t e;
      bus.fu_value[2*XW +: XW] = XW'(32'hDEAD_BEEF);
      bus.fu_take_branch[2]    = 1'b1;
      e = '0;
      e.v[0]       = 1'b1;
      e.tag[0+:TW] = TW'(3);
      e.val[0+:XW] = XW'(32'hDEAD_BEEF);
      e.tb[0]      = 1'b1;
      cyc(1'b0, 1'b0, 4'b0100, 4'b0100, e, "deadbeef");
      bus.fu_value[2*XW +: XW] = val_of(2);
    end
    cyc(1'b0, 1'b0, 4'b0000, 4'b0000, mk(2'b00, 0, 0), "idle");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
